// File: rtl/poker_pkg.sv
// Shared poker constants: card widths/ranges, hand codes, payouts, judge FSM states.
package poker_pkg;

  localparam int CARD_NUM_W  = 4;
  localparam int CARD_SUIT_W = 3;
  localparam int NUM_MIN     = 1;
  localparam int NUM_MAX     = 13;
  localparam int SUIT_MIN    = 1;
  localparam int SUIT_MAX    = 4;

  localparam int HIST_W = 3;
  localparam logic [HIST_W-1:0] HIST_SAT = 3'd5;
  localparam logic [HIST_W-1:0] RUN_LEN  = 3'd5;

  localparam logic [3:0] RANK_NONE     = 4'd0;
  localparam logic [3:0] RANK_PAIR     = 4'd1;
  localparam logic [3:0] RANK_TWO_PAIR = 4'd2;
  localparam logic [3:0] RANK_TRIPS    = 4'd3;
  localparam logic [3:0] RANK_STRAIGHT = 4'd4;
  localparam logic [3:0] RANK_FLUSH    = 4'd5;
  localparam logic [3:0] RANK_FULL     = 4'd6;
  localparam logic [3:0] RANK_QUADS    = 4'd7;
  localparam logic [3:0] RANK_SFLUSH   = 4'd8;
  localparam logic [3:0] RANK_ROYAL    = 4'd9;

  localparam logic [7:0] PAY_NONE     = 8'd0;
  localparam logic [7:0] PAY_PAIR     = 8'd0;
  localparam logic [7:0] PAY_TWO_PAIR = 8'd1;
  localparam logic [7:0] PAY_TRIPS    = 8'd1;
  localparam logic [7:0] PAY_STRAIGHT = 8'd3;
  localparam logic [7:0] PAY_FLUSH    = 8'd4;
  localparam logic [7:0] PAY_FULL     = 8'd10;
  localparam logic [7:0] PAY_QUADS    = 8'd20;
  localparam logic [7:0] PAY_SFLUSH   = 8'd25;
  localparam logic [7:0] PAY_ROYAL    = 8'd250;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_TALLY,
    ST_CLASSIFY
  } state_t;

endpackage

// File: rtl/hand_classify.sv
// Priority encoder from tallied hand features to hand code and payout.
module hand_classify
  import poker_pkg::*;
(
  input  logic       err,
  input  logic       straight,
  input  logic       flush,
  input  logic       royal,
  input  logic [1:0] pairs,
  input  logic [1:0] trips,
  input  logic [1:0] quads,
  output logic [3:0] rank,
  output logic [7:0] payout
);

  always_comb begin
    rank   = RANK_NONE;
    payout = PAY_NONE;
    priority case (1'b1)
      err: begin
        rank   = RANK_NONE;
        payout = PAY_NONE;
      end
      (straight && flush && royal): begin
        rank   = RANK_ROYAL;
        payout = PAY_ROYAL;
      end
      (straight && flush): begin
        rank   = RANK_SFLUSH;
        payout = PAY_SFLUSH;
      end
      (quads != 2'd0): begin
        rank   = RANK_QUADS;
        payout = PAY_QUADS;
      end
      (trips != 2'd0 && pairs != 2'd0): begin
        rank   = RANK_FULL;
        payout = PAY_FULL;
      end
      flush: begin
        rank   = RANK_FLUSH;
        payout = PAY_FLUSH;
      end
      straight: begin
        rank   = RANK_STRAIGHT;
        payout = PAY_STRAIGHT;
      end
      (trips != 2'd0): begin
        rank   = RANK_TRIPS;
        payout = PAY_TRIPS;
      end
      (pairs == 2'd2): begin
        rank   = RANK_TWO_PAIR;
        payout = PAY_TWO_PAIR;
      end
      (pairs == 2'd1): begin
        rank   = RANK_PAIR;
        payout = PAY_PAIR;
      end
      default: begin
        rank   = RANK_NONE;
        payout = PAY_NONE;
      end
    endcase
  end

endmodule

// File: rtl/hand_judge.sv
// Multi-cycle poker hand judge: scan, rank histogram tally, classify.
// Define JUDGE_DUP_CHECK_EN to flag duplicate cards as an error.
module hand_judge
  import poker_pkg::*;
#(
  parameter int NUM_W  = CARD_NUM_W,
  parameter int SUIT_W = CARD_SUIT_W
) (
  input  logic              clock,
  input  logic              reset_c,
  input  logic              start,
  input  logic [NUM_W-1:0]  num0,
  input  logic [NUM_W-1:0]  num1,
  input  logic [NUM_W-1:0]  num2,
  input  logic [NUM_W-1:0]  num3,
  input  logic [NUM_W-1:0]  num4,
  input  logic [SUIT_W-1:0] suit0,
  input  logic [SUIT_W-1:0] suit1,
  input  logic [SUIT_W-1:0] suit2,
  input  logic [SUIT_W-1:0] suit3,
  input  logic [SUIT_W-1:0] suit4,
  output logic              busy,
  output logic              done,
  output logic [3:0]        rank,
  output logic [7:0]        payout,
  output logic              err
);

  localparam int HIST_N = 2 ** NUM_W;

  state_t            state;
  logic [NUM_W-1:0]  nums  [5];
  logic [SUIT_W-1:0] suits [5];
  logic [HIST_W-1:0] hist  [HIST_N];
  logic [2:0]        idx;
  logic [3:0]        step;
  logic [HIST_W-1:0] run;
  logic              bad;
  logic              flush;
  logic              straight;
  logic              royal;
  logic [1:0]        pairs;
  logic [1:0]        trips;
  logic [1:0]        quads;

  logic [NUM_W-1:0]  cur_num;
  logic [SUIT_W-1:0] cur_suit;
  logic              bad_card;
  logic              dup;
  logic [NUM_W-1:0]  bin;
  logic [HIST_W-1:0] hv;
  logic [HIST_W-1:0] run_nx;
  logic [3:0]        c_rank;
  logic [7:0]        c_payout;

  always_comb begin
    cur_num  = nums[idx];
    cur_suit = suits[idx];
    bad_card = int'(cur_num) < NUM_MIN
            || int'(cur_num) > NUM_MAX
            || int'(cur_suit) < SUIT_MIN
            || int'(cur_suit) > SUIT_MAX;
    dup = 1'b0;
`ifdef JUDGE_DUP_CHECK_EN
    for (int j = 0; j < 4; j++) begin
      if (j < int'(idx)
          && nums[j] == cur_num
          && suits[j] == cur_suit)
        dup = 1'b1;
    end
`endif
    // Step 13 revisits the ace so 10-J-Q-K-A closes the run.
    bin = (step == 4'd13) ? NUM_W'(1)
                          : NUM_W'(step + 4'd1);
    hv = hist[bin];
    if (hv == '0)
      run_nx = '0;
    else if (run == RUN_LEN)
      run_nx = run;
    else
      run_nx = run + 3'd1;
  end

  hand_classify u_classify (
    .err      (bad),
    .straight (straight),
    .flush    (flush),
    .royal    (royal),
    .pairs    (pairs),
    .trips    (trips),
    .quads    (quads),
    .rank     (c_rank),
    .payout   (c_payout)
  );

  always_ff @(posedge clock or negedge reset_c) begin
    if (!reset_c) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rank     <= RANK_NONE;
      payout   <= PAY_NONE;
      bad      <= 1'b0;
      flush    <= 1'b0;
      straight <= 1'b0;
      royal    <= 1'b0;
      pairs    <= '0;
      trips    <= '0;
      quads    <= '0;
      run      <= '0;
      step     <= '0;
      idx      <= '0;
      for (int i = 0; i < HIST_N; i++)
        hist[i] <= '0;
      for (int i = 0; i < 5; i++) begin
        nums[i]  <= '0;
        suits[i] <= '0;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            nums[0]  <= num0;
            nums[1]  <= num1;
            nums[2]  <= num2;
            nums[3]  <= num3;
            nums[4]  <= num4;
            suits[0] <= suit0;
            suits[1] <= suit1;
            suits[2] <= suit2;
            suits[3] <= suit3;
            suits[4] <= suit4;
            for (int i = 0; i < HIST_N; i++)
              hist[i] <= '0;
            bad      <= 1'b0;
            flush    <= 1'b1;
            straight <= 1'b0;
            royal    <= 1'b0;
            pairs    <= '0;
            trips    <= '0;
            quads    <= '0;
            run      <= '0;
            step     <= '0;
            idx      <= '0;
            rank     <= RANK_NONE;
            payout   <= PAY_NONE;
            err      <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (bad_card || dup)
            bad <= 1'b1;
          else if (hist[cur_num] != HIST_SAT)
            hist[cur_num] <= hist[cur_num] + 3'd1;
          if (cur_suit != suits[0])
            flush <= 1'b0;
          if (idx == 3'd4) begin
            idx   <= '0;
            state <= ST_TALLY;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        ST_TALLY: begin
          if (step != 4'd13) begin
            if (hv == 3'd2)
              pairs <= pairs + 2'd1;
            if (hv == 3'd3)
              trips <= trips + 2'd1;
            // Five identical cards saturate at 5 and still count as quads.
            if (hv >= 3'd4)
              quads <= quads + 2'd1;
          end
          run <= run_nx;
          if (run_nx == RUN_LEN) begin
            straight <= 1'b1;
            if (step == 4'd13)
              royal <= 1'b1;
          end
          if (step == 4'd13) begin
            step  <= '0;
            state <= ST_CLASSIFY;
          end else begin
            step <= step + 4'd1;
          end
        end
        ST_CLASSIFY: begin
          rank   <= c_rank;
          payout <= c_payout;
          err    <= bad;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hand_judge.sv
// Scoreboard bench for hand_judge: directed poker hands plus random deals.
module tb_hand_judge;

  logic       clock = 1'b0;
  logic       reset_c = 1'b0;
  logic       start = 1'b0;
  logic [3:0] num0 = '0, num1 = '0, num2 = '0, num3 = '0, num4 = '0;
  logic [2:0] suit0 = '0, suit1 = '0, suit2 = '0, suit3 = '0, suit4 = '0;
  logic       busy, done, err;
  logic [3:0] rank;
  logic [7:0] payout;

  int     checks = 0;
  int     fails = 0;
  longint cyc = 0;
  logic   prev_done = 1'b0;

  typedef struct {
    int     rk;
    int     pay;
    bit     e;
    longint at;
  } exp_t;

  exp_t sb[$];

  hand_judge dut (
    .clock   (clock),
    .reset_c (reset_c),
    .start   (start),
    .num0    (num0),
    .num1    (num1),
    .num2    (num2),
    .num3    (num3),
    .num4    (num4),
    .suit0   (suit0),
    .suit1   (suit1),
    .suit2   (suit2),
    .suit3   (suit3),
    .suit4   (suit4),
    .busy    (busy),
    .done    (done),
    .rank    (rank),
    .payout  (payout),
    .err     (err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Poker rules from card multiset, independent of any scan order.
  function automatic void model(input int n[5], input int s[5],
                                output int rk, output int pay, output bit e);
    int cnt[16];
    int pr, tr, qd, distinct, mn, mx;
    bit fl, st, ry;
    e = 0;
    fl = 1;
    pr = 0; tr = 0; qd = 0; distinct = 0; mn = 99; mx = 0;
    for (int i = 0; i < 16; i++) cnt[i] = 0;
    for (int i = 0; i < 5; i++) begin
      if (n[i] < 1 || n[i] > 13 || s[i] < 1 || s[i] > 4) e = 1;
      if (s[i] != s[0]) fl = 0;
      cnt[n[i] & 15]++;
    end
`ifdef JUDGE_DUP_CHECK_EN
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < i; j++)
        if (n[i] == n[j] && s[i] == s[j]) e = 1;
`endif
    for (int v = 1; v <= 13; v++) begin
      if (cnt[v] == 2) pr++;
      if (cnt[v] == 3) tr++;
      if (cnt[v] >= 4) qd++;
      if (cnt[v] > 0) begin
        distinct++;
        if (v < mn) mn = v;
        if (v > mx) mx = v;
      end
    end
    ry = distinct == 5 && cnt[1] > 0 && cnt[10] > 0 && cnt[11] > 0
         && cnt[12] > 0 && cnt[13] > 0;
    st = distinct == 5 && (mx - mn == 4 || ry);
    if (e)                  begin rk = 0; pay = 0;   end
    else if (st && fl && ry) begin rk = 9; pay = 250; end
    else if (st && fl)      begin rk = 8; pay = 25;  end
    else if (qd > 0)        begin rk = 7; pay = 20;  end
    else if (tr > 0 && pr > 0) begin rk = 6; pay = 10; end
    else if (fl)            begin rk = 5; pay = 4;   end
    else if (st)            begin rk = 4; pay = 3;   end
    else if (tr > 0)        begin rk = 3; pay = 1;   end
    else if (pr == 2)       begin rk = 2; pay = 1;   end
    else if (pr == 1)       begin rk = 1; pay = 0;   end
    else                    begin rk = 0; pay = 0;   end
  endfunction

  always @(negedge clock) begin
    if (reset_c && done) begin
      if (prev_done) begin
        checks++;
        fails++;
        $display("FAIL done_width: done high on consecutive cycles");
      end
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL spurious_done: done=1 with no judgement pending");
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("rank", rank, x.rk);
        chk("payout", payout, x.pay);
        chk("err", err, x.e);
        chk("latency", cyc - x.at, 20);
        chk("busy_at_done", busy, 0);
      end
    end
    prev_done <= done;
  end

  task automatic set_cards(input int n[5], input int s[5]);
    num0 = 4'(n[0]); num1 = 4'(n[1]); num2 = 4'(n[2]);
    num3 = 4'(n[3]); num4 = 4'(n[4]);
    suit0 = 3'(s[0]); suit1 = 3'(s[1]); suit2 = 3'(s[2]);
    suit3 = 3'(s[3]); suit4 = 3'(s[4]);
  endtask

  task automatic issue(input int n[5], input int s[5], input bit hold);
    exp_t x;
    @(negedge clock);
    set_cards(n, s);
    start = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) start = 1'b0;
    model(n, s, x.rk, x.pay, x.e);
    x.at = cyc;
    sb.push_back(x);
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || sb.size() != 0) && k < 100) begin
      @(negedge clock);
      k++;
    end
    checks++;
    if (busy || sb.size() != 0) begin
      fails++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d", busy, sb.size());
    end
  endtask

  int dn[13][5] = '{
    '{10, 11, 12, 13, 1}, '{1, 2, 3, 4, 5},   '{12, 13, 1, 2, 3},
    '{7, 7, 7, 9, 9},     '{4, 4, 8, 8, 13},  '{5, 5, 5, 5, 2},
    '{2, 3, 14, 5, 6},    '{2, 3, 4, 5, 6},   '{3, 3, 8, 9, 11},
    '{6, 6, 6, 6, 6},     '{5, 6, 7, 8, 9},   '{2, 5, 9, 11, 13},
    '{8, 8, 8, 2, 12}
  };
  int ds[13][5] = '{
    '{1, 1, 1, 1, 1}, '{1, 2, 3, 4, 1}, '{2, 1, 3, 4, 1},
    '{1, 2, 3, 1, 2}, '{1, 2, 1, 3, 4}, '{1, 2, 3, 4, 1},
    '{1, 1, 1, 1, 1}, '{1, 2, 3, 0, 1}, '{2, 2, 1, 3, 4},
    '{1, 1, 1, 1, 1}, '{3, 3, 3, 3, 3}, '{4, 4, 4, 4, 4},
    '{1, 2, 3, 4, 1}
  };

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n[5];
    int s[5];
    int m[5];
    int t[5];
    exp_t h;
    longint a;
    int k;

    repeat (3) @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rank", rank, 0);
    chk("reset_payout", payout, 0);
    chk("reset_err", err, 0);
    reset_c = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 13; i++) begin
      for (int j = 0; j < 5; j++) begin
        n[j] = dn[i][j];
        s[j] = ds[i][j];
      end
      issue(n, s, 1'b0);
      wait_idle();
    end

    // Royal flush, then check outputs hold while idle.
    for (int j = 0; j < 5; j++) begin n[j] = dn[0][j]; s[j] = ds[0][j]; end
    issue(n, s, 1'b0);
    wait_idle();
    repeat (5) @(negedge clock);
    chk("hold_rank", rank, 9);
    chk("hold_payout", payout, 250);

    // Start pulsed while busy, with different cards on the inputs.
    for (int j = 0; j < 5; j++) begin n[j] = dn[4][j]; s[j] = ds[4][j]; end
    for (int j = 0; j < 5; j++) begin m[j] = dn[3][j]; t[j] = ds[3][j]; end
    issue(n, s, 1'b0);
    repeat (7) @(posedge clock);
    @(negedge clock);
    set_cards(m, t);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (25) @(negedge clock);
    chk("no_retrigger_busy", busy, 0);

    // Reset mid-judgement after E10.
    issue(m, t, 1'b0);
    repeat (10) @(posedge clock);
    #1;
    reset_c = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rank", rank, 0);
    chk("abort_payout", payout, 0);
    chk("abort_err", err, 0);
    @(negedge clock);
    reset_c = 1'b1;
    repeat (30) @(negedge clock);
    chk("abort_idle_busy", busy, 0);
    issue(m, t, 1'b0);
    wait_idle();

    // start held high: three back-to-back judgements 21 cycles apart.
    for (int j = 0; j < 5; j++) begin n[j] = dn[1][j]; s[j] = ds[1][j]; end
    issue(n, s, 1'b1);
    h = sb[sb.size() - 1];
    a = h.at;
    h.at = a + 21;
    sb.push_back(h);
    h.at = a + 42;
    sb.push_back(h);
    k = 0;
    while (cyc < a + 62 && k < 200) begin
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    wait_idle();

    // Random deals clustered around a base value to hit made hands.
    for (int r = 0; r < 250; r++) begin
      int base;
      bit same;
      base = $urandom_range(1, 13);
      same = ($urandom_range(0, 2) == 0);
      for (int j = 0; j < 5; j++) begin
        n[j] = ((base - 1 + $urandom_range(0, 5)) % 13) + 1;
        s[j] = same ? 2 : $urandom_range(1, 4);
      end
      if ($urandom_range(0, 9) == 0)
        n[$urandom_range(0, 4)] = $urandom_range(0, 1) ? 0 : $urandom_range(14, 15);
      if ($urandom_range(0, 14) == 0)
        s[$urandom_range(0, 4)] = $urandom_range(0, 1) ? 0 : $urandom_range(5, 7);
      issue(n, s, 1'b0);
      wait_idle();
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
